div_check_sequencer: RTL and testbench
======================================

Name: div_check_sequencer

Overview:
Upstream driver and downstream checker for the 32-bit sequential divider. It issues operand pairs and a one-cycle start pulse, then captures quotient and remainder on the rising edge of the divider's finish flag. Each result is checked arithmetically and its latency in clock cycles is recorded. The measured latency feeds the team's delay-based Trojan detection flow; an abnormal latency or a wrong result is the signature that flow looks for.

Parameters:
WIDTH, 32, operand/result width
NUM_OPS, 16, operations per run in LFSR mode
TIMEOUT, 2048, max cycles waiting for finish before aborting the op
SEED_A, 32'hACE1_2468, dividend LFSR seed (nonzero)
SEED_B, 32'h1357_BDF1, divisor LFSR seed (nonzero)
LAT_MIN, 0, lower latency bound (used only with optional feature)
LAT_MAX, 1023, upper latency bound (used only with optional feature)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  rising edge in IDLE starts a run
ext_mode  in  1  1: single op using ext_a/ext_b; 0: NUM_OPS LFSR ops
ext_a  in  WIDTH  external dividend
ext_b  in  WIDTH  external divisor
div_a  out  WIDTH  dividend to divider, held stable from ISSUE to CHECK
div_b  out  WIDTH  divisor to divider, held stable from ISSUE to CHECK
div_start  out  1  one-cycle start pulse
div_q  in  WIDTH  divider quotient
div_r  in  WIDTH  divider remainder
div_finish  in  1  divider finish flag (level)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on run completion
err  out  1  sticky; any mismatch or timeout this run
err_count  out  16  failed ops this run, saturates at 16'hFFFF
op_count  out  16  ops completed this run
last_lat  out  16  latency of most recent op
max_lat  out  16  max latency this run

Behaviour:
- Reset (async): state IDLE; all outputs 0; LFSRs loaded with their seeds; prev_finish=0.
- Run edge detection: run_d is registered; a run starts when run & ~run_d in IDLE. A run edge outside IDLE is ignored.
- On run start: clear err, err_count, op_count, max_lat.
- States:
  - IDLE: wait for a run edge, then go to LOAD.
  - LOAD: load div_a/div_b. In ext_mode, use ext_a/ext_b. Otherwise use the LFSR values and step both LFSRs (Galois, taps 32,22,2,1). If the selected divisor is 0, substitute 1; this applies in ext_mode too. Next state is ISSUE.
  - ISSUE: div_start=1 for exactly this cycle; lat_cnt=0. Next state is WAIT.
  - WAIT: lat_cnt increments each cycle, saturating at 16'hFFFF. prev_finish tracks div_finish.
    - div_finish & ~prev_finish: capture div_q/div_r, set last_lat = lat_cnt+1, go to CHECK.
    - lat_cnt reaches TIMEOUT first: count an error, set last_lat = 16'hFFFF, go to NEXT.
    - A finish level already high on entry to WAIT is not a completion; only a rising edge counts.
  - CHECK (one cycle): pass iff {WIDTH'b0,q}*b + r == {WIDTH'b0,a}, using a 2*WIDTH-bit product, and r < b. On fail, set err and increment err_count. Update max_lat. Go to NEXT.
  - NEXT: increment op_count. If ext_mode, or op_count+1 == NUM_OPS, pulse done and go to IDLE; otherwise go to LOAD.
- Run latency: 4 overhead cycles plus divider latency per op.
- rst asserted mid-run aborts immediately to reset values. div_start drops in the same cycle.
- LFSRs are not reseeded per run; only rst reseeds them.

Optional Feature:
Macro LATENCY_WINDOW_EN.
- Defined: in CHECK, an op also fails if last_lat < LAT_MIN or last_lat > LAT_MAX. Such a fail sets err and increments err_count, and an extra sticky output lat_err (1 bit, reset 0, cleared at run start) is set.
- Undefined: LAT_MIN/LAT_MAX are unused, the lat_err port does not exist, and only the arithmetic check and timeout set err.

Test Plan:
- ext_mode=1, ext_a=1265, ext_b=10, divider model with 34-cycle latency → div_start pulse 1 cycle; q=126, r=5 captured; err=0; op_count=1; last_lat=34; done pulse.
- ext_mode=1, ext_a=527, ext_b=0 → div_b=1 is driven; model returns q=527, r=0; err=0.
- ext_mode=0, NUM_OPS=16, correct model → 16 start pulses; op_count=16; err_count=0; max_lat equals the model's max latency.
- Faulty model returning r+1 on op 3 → err=1 and err_count=1 after the run; all other ops pass.
- Model never raises finish, TIMEOUT=64 → after 64 WAIT cycles err=1 and last_lat=16'hFFFF; the next op proceeds normally.
- rst asserted during WAIT of op 5, plus run edge while busy → all outputs return to 0 immediately; the busy-time run edge has no effect. With LATENCY_WINDOW_EN, LAT_MAX=20, and a 34-cycle model → lat_err=1.

Source files
------------

// File: rtl/div_check_sequencer_if.sv
// div_check_sequencer_if: operand/result handshake between the check sequencer and the divider
interface div_check_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_start;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic             div_finish;

    modport master (
        output div_a, div_b, div_start,
        input  div_q, div_r, div_finish
    );

    modport slave (
        input  div_a, div_b, div_start,
        output div_q, div_r, div_finish
    );
endinterface

// File: rtl/div_check_sequencer.sv
// div_check_sequencer: drives a sequential divider, checks q*b+r==a and r<b, measures latency
// Optional macro LATENCY_WINDOW_EN adds a latency window check [LAT_MIN, LAT_MAX] and a sticky lat_err output.
module div_check_sequencer #(
    parameter int          WIDTH   = 32,
    parameter int          NUM_OPS = 16,
    parameter int          TIMEOUT = 2048,
    parameter logic [31:0] SEED_A  = 32'hACE1_2468,
    parameter logic [31:0] SEED_B  = 32'h1357_BDF1,
    parameter int          LAT_MIN = 0,
    parameter int          LAT_MAX = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  ext_mode,
    input  logic [WIDTH-1:0]      ext_a,
    input  logic [WIDTH-1:0]      ext_b,
    div_check_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           err_count,
    output logic [15:0]           op_count,
    output logic [15:0]           last_lat,
    output logic [15:0]           max_lat
`ifdef LATENCY_WINDOW_EN
    ,
    output logic                  lat_err
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, CHECK, NEXT} state_t;

    state_t             state;
    state_t             state_nx;
    logic               run_d;
    logic               prev_finish;
    logic [31:0]        lfsr_a;
    logic [31:0]        lfsr_b;
    logic [15:0]        lat_cnt;
    logic [WIDTH-1:0]   q_cap;
    logic [WIDTH-1:0]   r_cap;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [2*WIDTH-1:0] recon;
    logic               run_edge;
    logic               fin_edge;
    logic               timed_out;
    logic               last_op;
    logic               arith_ok;
    logic               op_fail;
    logic [15:0]        err_count_inc;

    // Galois LFSR for x^32 + x^22 + x^2 + x + 1, shifting right
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    assign run_edge      = run & ~run_d;
    assign fin_edge      = bus.div_finish & ~prev_finish;
    assign timed_out     = lat_cnt >= 16'(TIMEOUT - 1);
    assign last_op       = ext_mode || (op_count + 16'd1 == 16'(NUM_OPS));
    assign sel_a         = ext_mode ? ext_a : WIDTH'(lfsr_a);
    assign sel_b         = ext_mode ? ext_b : WIDTH'(lfsr_b);
    assign recon         = {{WIDTH{1'b0}}, q_cap} * {{WIDTH{1'b0}}, bus.div_b} + {{WIDTH{1'b0}}, r_cap};
    assign arith_ok      = (recon == {{WIDTH{1'b0}}, bus.div_a}) && (r_cap < bus.div_b);
    assign err_count_inc = err_count + {15'b0, err_count != 16'hFFFF};

`ifdef LATENCY_WINDOW_EN
    logic lat_bad;
    assign lat_bad = (int'(last_lat) < LAT_MIN) || (int'(last_lat) > LAT_MAX);
    assign op_fail = !arith_ok || lat_bad;
`else
    logic unused_lat_bounds;
    assign unused_lat_bounds = ^{LAT_MIN, LAT_MAX};
    assign op_fail           = !arith_ok;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: one op is LOAD, ISSUE, WAIT..., CHECK, NEXT; a timeout skips CHECK
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = run_edge ? LOAD : IDLE;
            LOAD:    state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = fin_edge ? CHECK : (timed_out ? NEXT : WAIT);
            CHECK:   state_nx = NEXT;
            NEXT:    state_nx = last_op ? IDLE : LOAD;
            default: state_nx = IDLE;
        endcase
    end

    // Decoded outputs; div_start falls with the async reset of the state register
    always_comb begin
        bus.div_start = state == ISSUE;
        busy          = state != IDLE;
        done          = (state == NEXT) && last_op;
    end

    // Datapath: operands, LFSRs, latency counter, result capture and run statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_d       <= 1'b0;
            prev_finish <= 1'b0;
            lfsr_a      <= SEED_A;
            lfsr_b      <= SEED_B;
            lat_cnt     <= '0;
            q_cap       <= '0;
            r_cap       <= '0;
            bus.div_a   <= '0;
            bus.div_b   <= '0;
            err         <= 1'b0;
            err_count   <= '0;
            op_count    <= '0;
            last_lat    <= '0;
            max_lat     <= '0;
`ifdef LATENCY_WINDOW_EN
            lat_err     <= 1'b0;
`endif
        end else begin
            run_d       <= run;
            prev_finish <= bus.div_finish;
            if (state == IDLE && run_edge) begin
                err       <= 1'b0;
                err_count <= '0;
                op_count  <= '0;
                max_lat   <= '0;
`ifdef LATENCY_WINDOW_EN
                lat_err   <= 1'b0;
`endif
            end
            if (state == LOAD) begin
                bus.div_a <= sel_a;
                bus.div_b <= (sel_b == '0) ? WIDTH'(1) : sel_b;
                if (!ext_mode) begin
                    lfsr_a <= lfsr_step(lfsr_a);
                    lfsr_b <= lfsr_step(lfsr_b);
                end
            end
            if (state == ISSUE) lat_cnt <= '0;
            if (state == WAIT) begin
                lat_cnt <= (lat_cnt == 16'hFFFF) ? lat_cnt : lat_cnt + 16'd1;
                if (fin_edge) begin
                    q_cap    <= bus.div_q;
                    r_cap    <= bus.div_r;
                    last_lat <= (lat_cnt == 16'hFFFF) ? lat_cnt : lat_cnt + 16'd1;
                end else if (timed_out) begin
                    err       <= 1'b1;
                    err_count <= err_count_inc;
                    last_lat  <= 16'hFFFF;
                end
            end
            if (state == CHECK) begin
                if (op_fail) begin
                    err       <= 1'b1;
                    err_count <= err_count_inc;
                end
`ifdef LATENCY_WINDOW_EN
                if (lat_bad) lat_err <= 1'b1;
`endif
                max_lat <= (last_lat > max_lat) ? last_lat : max_lat;
            end
            if (state == NEXT) op_count <= op_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_div_check_sequencer.sv
// tb_div_check_sequencer: random-latency divider responder plus a timeline/scoreboard model of each run
module tb_div_check_sequencer;
    localparam int T = 64;
    localparam int N = 16;
`ifdef LATENCY_WINDOW_EN
    localparam bit WIN = 1'b1;
`else
    localparam bit WIN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        ext_mode = 1'b0;
    logic [31:0] ext_a = '0;
    logic [31:0] ext_b = '0;
    logic        busy, done, err;
    logic [15:0] err_count, op_count, last_lat, max_lat;
`ifdef LATENCY_WINDOW_EN
    logic        lat_err;
`endif

    div_check_sequencer_if #(.WIDTH(32)) bus ();

    div_check_sequencer #(
        .WIDTH(32), .NUM_OPS(N), .TIMEOUT(T)
`ifdef LATENCY_WINDOW_EN
        , .LAT_MAX(20)
`endif
    ) dut (
        .clk(clk), .rst(rst), .run(run), .ext_mode(ext_mode), .ext_a(ext_a), .ext_b(ext_b),
        .bus(bus), .busy(busy), .done(done), .err(err), .err_count(err_count),
        .op_count(op_count), .last_lat(last_lat), .max_lat(max_lat)
`ifdef LATENCY_WINDOW_EN
        , .lat_err(lat_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    endtask

    // Run plan: per-op operands and divider behaviour, plus derived expectations
    int          n_ops = 0;
    logic [31:0] pa[N], pb[N];
    int          plat[N], phold[N];
    bit          pfault[N], phang[N], ppre[N];
    int          s[N];
    int          lrec[N];
    int          cfail[N+1], cmax[N+1], cwin[N+1];
    int          done_cyc = 0;
    bit          have_plan = 1'b0;
    int          cyc = 0;
    logic [31:0] lfa, lfb;

    function automatic logic [31:0] lstep(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic bit win_bad(input int l);
        return WIN && (l > 20);
    endfunction

    task automatic cfg(input int i, input int lat, input int hold, input bit f, input bit h, input bit p);
        plat[i] = lat; phold[i] = hold; pfault[i] = f; phang[i] = h; ppre[i] = p;
    endtask

    task automatic rand_cfg(input int lat_max, input bit faults, input bit hangs);
        for (int i = 0; i < N; i++) begin
            cfg(i, $urandom_range(4, lat_max), $urandom_range(1, 2),
                faults && ($urandom_range(0, 7) == 0), hangs && ($urandom_range(0, 15) == 0),
                $urandom_range(0, 3) == 0);
            if (phang[i]) begin pfault[i] = 1'b0; ppre[i] = 1'b0; end
        end
    endtask

    task automatic set_ext(input logic [31:0] a, input logic [31:0] b);
        ext_mode = 1'b1; ext_a = a; ext_b = b;
        pa[0] = a; pb[0] = (b == 0) ? 32'd1 : b;
    endtask

    task automatic set_lfsr();
        ext_mode = 1'b0;
        for (int i = 0; i < N; i++) begin
            pa[i] = lfa; pb[i] = (lfb == 0) ? 32'd1 : lfb;
            lfa = lstep(lfa); lfb = lstep(lfb);
        end
    endtask

    // Each op costs latency+4 cycles (LOAD, ISSUE, CHECK, NEXT); a timeout costs T+3 (no CHECK)
    task automatic plan(input int n, input int c);
        int t;
        t = c + 2;
        n_ops = n; cfail[0] = 0; cmax[0] = 0; cwin[0] = 0;
        for (int i = 0; i < n; i++) begin
            s[i] = t;
            lrec[i] = phang[i] ? 65535 : plat[i];
            cfail[i+1] = cfail[i] + int'(phang[i] || pfault[i] || (!phang[i] && win_bad(plat[i])));
            cwin[i+1] = cwin[i] + int'(!phang[i] && win_bad(plat[i]));
            cmax[i+1] = (!phang[i] && plat[i] > cmax[i]) ? plat[i] : cmax[i];
            done_cyc = t + (phang[i] ? T + 1 : plat[i] + 2);
            t += phang[i] ? T + 3 : plat[i] + 4;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_op_count"}, op_count, 0);
        chk({tag, "_last_lat"}, last_lat, 0);
        chk({tag, "_max_lat"}, max_lat, 0);
        chk({tag, "_div_start"}, bus.div_start, 0);
        chk({tag, "_div_a"}, bus.div_a, 0);
        chk({tag, "_div_b"}, bus.div_b, 0);
    endtask

    // Statistics expected once ops 0..i-1 of the run are finished
    task automatic stat_checks(input int i);
        chk("op_count", op_count, i);
        chk("err_count", err_count, cfail[i]);
        chk("err", err, cfail[i] > 0);
        chk("max_lat", max_lat, cmax[i]);
        if (i > 0) chk("last_lat", last_lat, lrec[i-1]);
`ifdef LATENCY_WINDOW_EN
        chk("lat_err", lat_err, cwin[i] > 0);
`endif
    endtask

    task automatic compare_cycle();
        bit es;
        int k;
        es = 1'b0; k = -1;
        if (have_plan) for (int i = 0; i < n_ops; i++) if (cyc == s[i]) begin es = 1'b1; k = i; end
        chk("div_start", bus.div_start, es);
        chk("busy", busy, have_plan && cyc >= s[0] - 1 && cyc <= done_cyc);
        chk("done", done, have_plan && cyc == done_cyc);
        if (k >= 0) begin
            chk("div_a", bus.div_a, pa[k]);
            chk("div_b", bus.div_b, pb[k]);
            stat_checks(k);
        end
        if (have_plan && cyc == done_cyc + 1) stat_checks(n_ops);
    endtask

    // Compare process: every cycle, shortly after the active edge
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) compare_cycle();
    end

    // Divider responder: true quotient/remainder after the planned latency, finish as a level
    int          resp_idx = 0;
    int          rk;
    logic [31:0] resp_a[N], resp_b[N];
    logic [31:0] rq = '0, rr = '0;

    initial begin
        bus.div_finish = 1'b0; bus.div_q = '0; bus.div_r = '0;
        forever begin
            @(negedge clk);
            if (bus.div_start === 1'b1 && resp_idx < N) begin
                rk = resp_idx; resp_idx++;
                resp_a[rk] = bus.div_a; resp_b[rk] = bus.div_b;
                rq = (bus.div_b != 0) ? bus.div_a / bus.div_b : 32'd0;
                rr = (bus.div_b != 0) ? bus.div_a % bus.div_b : 32'd0;
                if (pfault[rk]) rr = rr + 32'd1;
                if (!phang[rk]) begin
                    if (ppre[rk]) begin
                        bus.div_finish = 1'b1;
                        repeat (2) @(negedge clk);
                        bus.div_finish = 1'b0;
                        repeat (plat[rk] - 2) @(negedge clk);
                    end else repeat (plat[rk]) @(negedge clk);
                    bus.div_q = rq; bus.div_r = rr; bus.div_finish = 1'b1;
                    repeat (phold[rk]) @(negedge clk);
                    bus.div_finish = 1'b0;
                end
            end
        end
    end

    task automatic do_run(input int n, input bit mid_pulse, input int abort_op);
        @(negedge clk);
        plan(n, cyc);
        resp_idx = 0; have_plan = 1'b1; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        while (cyc <= done_cyc + 1) begin
            @(negedge clk);
            run = mid_pulse && (cyc == s[0] + 5);
            if (abort_op >= 0 && cyc == s[abort_op] + 3) begin
                have_plan = 1'b0; run = 1'b0;
                rst = 1'b1;
                #1;
                chk_zero("abort");
                repeat (2) @(negedge clk);
                rst = 1'b0;
                lfa = 32'hACE1_2468; lfb = 32'h1357_BDF1;
                break;
            end
        end
    endtask

    initial begin
        lfa = 32'hACE1_2468; lfb = 32'h1357_BDF1;
        for (int i = 0; i < N; i++) cfg(i, 10, 1, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        set_ext(32'd1265, 32'd10); cfg(0, 34, 1, 0, 0, 0); do_run(1, 0, -1);
        chk("ext1_q", rq, 126);
        chk("ext1_r", rr, 5);
        chk("ext1_last_lat", last_lat, 34);
        chk("ext1_max_lat", max_lat, 34);
        chk("ext1_op_count", op_count, 1);
        chk("ext1_err", err, WIN);
`ifdef LATENCY_WINDOW_EN
        chk("ext1_lat_err", lat_err, 1);
`endif

        set_ext(32'd527, 32'd0); cfg(0, 12, 2, 0, 0, 1); do_run(1, 0, -1);
        chk("ext0_div_b", bus.div_b, 1);
        chk("ext0_q", rq, 527);
        chk("ext0_r", rr, 0);
        chk("ext0_err", err, 0);

        set_ext(32'd1000, 32'd7); cfg(0, 10, 1, 0, 1, 0); do_run(1, 0, -1);
        chk("tmo_last_lat", last_lat, 16'hFFFF);
        chk("tmo_err", err, 1);
        chk("tmo_err_count", err_count, 1);

        set_ext(32'd1000, 32'd7); cfg(0, 9, 1, 0, 0, 0); do_run(1, 0, -1);
        chk("after_tmo_err", err, 0);
        chk("after_tmo_last_lat", last_lat, 9);
        chk("after_tmo_q", rq, 142);
        chk("after_tmo_r", rr, 6);

        set_lfsr(); rand_cfg(60, 0, 0); do_run(N, 1, -1);
        chk("lfsr_a0", resp_a[0], 32'hACE1_2468);
        chk("lfsr_b0", resp_b[0], 32'h1357_BDF1);
        chk("lfsr_a1", resp_a[1], 32'h5670_9234);
        chk("lfsr_b1", resp_b[1], 32'h898B_DEFB);
        chk("lfsr_op_count", op_count, 16);

        set_lfsr(); rand_cfg(20, 0, 0); pfault[3] = 1'b1; do_run(N, 0, -1);
        chk("fault3_err", err, 1);
        chk("fault3_err_count", err_count, 1);

        set_lfsr(); rand_cfg(20, 0, 0); phang[2] = 1'b1; ppre[2] = 1'b0; do_run(N, 0, -1);
        chk("hang2_err_count", err_count, 1);
        chk("hang2_op_count", op_count, 16);

        for (int r = 0; r < 3; r++) begin
            set_lfsr(); rand_cfg(60, 1, 1); do_run(N, r == 1, -1);
        end

        set_lfsr(); rand_cfg(30, 0, 0); cfg(5, 50, 1, 0, 0, 0); do_run(N, 1, 5);
        repeat (100) @(negedge clk);

        set_lfsr(); rand_cfg(40, 0, 0); do_run(N, 0, -1);
        chk("reseed_a0", resp_a[0], 32'hACE1_2468);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
